// File: rtl/sha1_msg_mem.sv
// sha1_msg_mem: message word store shared by the SHA-1 hash core (port A,
// byte addressed, one-cycle registered read) and a host load port that
// streams words into consecutive locations starting at load_base.
// Optional feature: define SHA1_MEM_ACCESS_COUNT_EN to add the rd_count and
// wr_count outputs (aligned port A reads/writes, wrapping at 2^32).
//
// state | meaning
// IDLE  | no load in progress, load_ready=0
// LOAD  | accepting words at the write pointer, load_ready=1
// DONE  | last word accepted, load_done=1 until the next load_start
module sha1_msg_mem #(
  parameter int DEPTH_WORDS = 16384,
  parameter int WADDR_W     = 14
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [15:0]        port_A_addr,
  input  logic               port_A_we,
  input  logic [31:0]        port_A_data_in,
  output logic [31:0]        port_A_data_out,
  input  logic               load_start,
  input  logic [WADDR_W-1:0] load_base,
  input  logic               load_valid,
  input  logic [31:0]        load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_done,
  output logic [WADDR_W:0]   load_words,
  output logic               align_err,
  output logic [15:0]        err_addr
`ifdef SHA1_MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WADDR_W-1:0] PTR_MAX   = WADDR_W'(DEPTH_WORDS - 1);
  localparam logic [WADDR_W:0]   WORDS_MAX = (WADDR_W + 1)'(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  state_t             state_q, state_d;
  logic [WADDR_W-1:0] ptr_q, ptr_d;
  logic [WADDR_W:0]   words_q, words_d;
  logic               align_err_q, align_err_d;
  logic [15:0]        err_addr_q, err_addr_d;
  logic [31:0]        dout_q, dout_d;

  logic [WADDR_W-1:0] pa_idx;
  logic               pa_mis;
  logic               pa_rd;
  logic               pa_wr;
  logic               ld_hs;

  assign pa_idx = port_A_addr[WADDR_W+1:2];
  assign pa_mis = |port_A_addr[1:0];
  assign pa_rd  = ~pa_mis & ~port_A_we;
  assign pa_wr  = ~pa_mis & port_A_we;
  // load_start wins over a same-cycle load_valid, so that word is dropped
  assign ld_hs  = (state_q == S_LOAD) & load_valid & ~load_start;

  // Memory writes; the load write comes last so it wins a same-word collision.
  // Reads of a word being written return the pre-edge contents.
  always_ff @(posedge clk) begin
    if (nreset) begin
      if (pa_wr) mem[pa_idx] <= port_A_data_in;
      if (ld_hs) mem[ptr_q] <= load_data;
    end
  end

  // Port A read register and sticky misalignment capture.
  always_comb begin
    dout_d      = dout_q;
    align_err_d = align_err_q | pa_mis;
    err_addr_d  = err_addr_q;
    if (pa_rd) dout_d = mem[pa_idx];
    if (pa_mis && !align_err_q) err_addr_d = port_A_addr;
  end

  // Load FSM next state, write pointer and saturating word count.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    words_d = words_q;
    if (load_start) begin
      state_d = S_LOAD;
      ptr_d   = load_base;
      words_d = '0;
    end else if (ld_hs) begin
      ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
      if (words_q != WORDS_MAX) words_d = words_q + 1'b1;
      if (load_last) state_d = S_DONE;
    end
  end

  // State registers with synchronous active-low reset; memory is untouched.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      words_q     <= '0;
      align_err_q <= 1'b0;
      err_addr_q  <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      words_q     <= words_d;
      align_err_q <= align_err_d;
      err_addr_q  <= err_addr_d;
      dout_q      <= dout_d;
    end
  end

  assign port_A_data_out = dout_q;
  assign load_ready      = (state_q == S_LOAD);
  assign load_done       = (state_q == S_DONE);
  assign load_words      = words_q;
  assign align_err       = align_err_q;
  assign err_addr        = err_addr_q;

`ifdef SHA1_MEM_ACCESS_COUNT_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // Aligned access counters, free-running modulo 2^32.
  always_comb begin
    rd_count_d = rd_count_q + {31'd0, pa_rd};
    wr_count_d = wr_count_q + {31'd0, pa_wr};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sha1_msg_mem.sv
// Bench for sha1_msg_mem: the driver steps a behavioural model each cycle and
// queues the expected outputs; a monitor pops and compares after every edge.
module tb_sha1_msg_mem;
  localparam int DEPTH = 16384;

  logic        clk;
  logic        nreset;
  logic [15:0] pa_addr;
  logic        pa_we;
  logic [31:0] pa_din;
  logic [31:0] pa_dout;
  logic        ls;
  logic [13:0] lb;
  logic        lv;
  logic [31:0] ld;
  logic        ll;
  logic        l_ready;
  logic        l_done;
  logic [14:0] l_words;
  logic        a_err;
  logic [15:0] e_addr;
`ifdef SHA1_MEM_ACCESS_COUNT_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  sha1_msg_mem dut (
    .clk             (clk),
    .nreset          (nreset),
    .port_A_addr     (pa_addr),
    .port_A_we       (pa_we),
    .port_A_data_in  (pa_din),
    .port_A_data_out (pa_dout),
    .load_start      (ls),
    .load_base       (lb),
    .load_valid      (lv),
    .load_data       (ld),
    .load_last       (ll),
    .load_ready      (l_ready),
    .load_done       (l_done),
    .load_words      (l_words),
    .align_err       (a_err),
    .err_addr        (e_addr)
`ifdef SHA1_MEM_ACCESS_COUNT_EN
    ,
    .rd_count        (rd_cnt),
    .wr_count        (wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [31:0] dout;
    logic        rdy;
    logic        done;
    logic [14:0] words;
    logic        aerr;
    logic [15:0] eaddr;
    logic [31:0] rdc;
    logic [31:0] wrc;
  } exp_t;

  exp_t exp_q[$];

  // reference model: memory plus a load phase (0 idle, 1 loading, 2 done)
  bit [31:0] ref_mem [DEPTH];
  int        m_phase = 0;
  int        m_ptr   = 0;
  int        m_words = 0;
  bit        m_aerr  = 0;
  bit [15:0] m_eaddr = 0;
  bit [31:0] m_dout  = 0;
  bit [31:0] m_rdc   = 0;
  bit [31:0] m_wrc   = 0;

  task automatic model_step();
    exp_t e;
    int   widx;
    if (!nreset) begin
      m_phase = 0; m_words = 0; m_aerr = 0; m_eaddr = 0;
      m_dout = 0; m_rdc = 0; m_wrc = 0;
    end else begin
      widx = int'(pa_addr >> 2);
      if (pa_addr[1:0] != 2'b00) begin
        if (!m_aerr) m_eaddr = pa_addr;
        m_aerr = 1;
      end else if (pa_we) begin
        ref_mem[widx] = pa_din;
        m_wrc++;
      end else begin
        m_dout = ref_mem[widx];
        m_rdc++;
      end
      if (ls) begin
        m_phase = 1; m_ptr = int'(lb); m_words = 0;
      end else if (m_phase == 1 && lv) begin
        ref_mem[m_ptr] = ld;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_words < DEPTH) m_words++;
        if (ll) m_phase = 2;
      end
    end
    e.dout = m_dout; e.rdy = (m_phase == 1); e.done = (m_phase == 2);
    e.words = 15'(m_words); e.aerr = m_aerr; e.eaddr = m_eaddr;
    e.rdc = m_rdc; e.wrc = m_wrc;
    exp_q.push_back(e);
  endtask

  // monitor: every edge presents a full output set to compare
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_dout",  pa_dout, e.dout);
      chk("sb_ready", 32'(l_ready), 32'(e.rdy));
      chk("sb_done",  32'(l_done), 32'(e.done));
      chk("sb_words", 32'(l_words), 32'(e.words));
      chk("sb_aerr",  32'(a_err), 32'(e.aerr));
      chk("sb_eaddr", 32'(e_addr), 32'(e.eaddr));
`ifdef SHA1_MEM_ACCESS_COUNT_EN
      chk("sb_rdcnt", rd_cnt, e.rdc);
      chk("sb_wrcnt", wr_cnt, e.wrc);
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic quiet();
    nreset = 1; pa_we = 0; pa_addr = 16'h0100; pa_din = 0;
    ls = 0; lb = 0; lv = 0; ld = 0; ll = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a);
    quiet(); pa_addr = a; tick();
  endtask

  task automatic start(input logic [13:0] base);
    quiet(); ls = 1; lb = base; tick();
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    quiet(); lv = 1; ld = d; ll = last; tick();
  endtask

  initial begin : drv
    int          hs;
    logic [31:0] prev;
    logic [31:0] saved;

    quiet(); nreset = 0; tick();
    chk("rst_dout", pa_dout, 32'h0);
    chk("rst_words", 32'(l_words), 32'h0);
    chk("rst_ready", 32'(l_ready), 32'h0);
    chk("rst_aerr", 32'(a_err), 32'h0);

    // fill every word and overrun the depth by three to reach saturation
    start(14'd0);
    chk("init_ready", 32'(l_ready), 32'h1);
    hs = 0;
    while (hs < DEPTH + 3) begin
      quiet();
      pa_we = 1; pa_addr = 16'h0000; pa_din = $urandom;
      lv = ($urandom_range(9) != 0); ld = $urandom;
      ll = lv && (hs == DEPTH + 2);
      if (lv) hs++;
      tick();
    end
    chk("sat_words", 32'(l_words), 32'd16384);
    chk("sat_done", 32'(l_done), 32'h1);

    // three-word load then read back
    start(14'd0);
    push(32'h01234567, 1'b0);
    push(32'h02468ACE, 1'b0);
    push(32'h048D159C, 1'b1);
    chk("l3_words", 32'(l_words), 32'd3);
    chk("l3_done", 32'(l_done), 32'h1);
    rd(16'h0000); chk("l3_w0", pa_dout, 32'h01234567);
    rd(16'h0004); chk("l3_w1", pa_dout, 32'h02468ACE);
    rd(16'h0008); chk("l3_w2", pa_dout, 32'h048D159C);

    // port A write then read
    prev = m_dout;
    quiet(); pa_we = 1; pa_addr = 16'h0010; pa_din = 32'hDEADBEEF; tick();
    chk("wr_hold", pa_dout, prev);
    rd(16'h0010); chk("wr_rd", pa_dout, 32'hDEADBEEF);

    // misaligned accesses after a reset clears the sticky flag
    quiet(); nreset = 0; tick();
    chk("rst2_aerr", 32'(a_err), 32'h0);
    rd(16'h0006);
    rd(16'h0009);
    chk("mis_aerr", 32'(a_err), 32'h1);
    chk("mis_eaddr", 32'(e_addr), 32'h0006);
    chk("mis_hold", pa_dout, 32'h0);
    rd(16'h0004); chk("mis_w1", pa_dout, 32'h02468ACE);
    rd(16'h0008); chk("mis_w2", pa_dout, 32'h048D159C);

    // wrap from the last word to word 0
    start(14'd16383);
    push(32'hCAFE0001, 1'b0);
    push(32'hCAFE0002, 1'b1);
    chk("wrap_words", 32'(l_words), 32'd2);
    rd(16'hFFFC); chk("wrap_top", pa_dout, 32'hCAFE0001);
    rd(16'h0000); chk("wrap_zero", pa_dout, 32'hCAFE0002);

    // same-word write collision: load wins
    start(14'd5);
    quiet(); lv = 1; ld = 32'h11111111; ll = 1;
    pa_we = 1; pa_addr = 16'h0014; pa_din = 32'h22222222; tick();
    rd(16'h0014); chk("coll_w5", pa_dout, 32'h11111111);

    // load write during port A read of same word returns old data
    saved = ref_mem[7];
    start(14'd7);
    quiet(); lv = 1; ld = 32'h33333333; ll = 1; pa_addr = 16'h001C; tick();
    chk("rdw_old", pa_dout, saved);
    rd(16'h001C); chk("rdw_new", pa_dout, 32'h33333333);

    // load_start during LOAD drops the same-cycle word
    saved = ref_mem[200];
    start(14'd200);
    quiet(); ls = 1; lb = 14'd300; lv = 1; ld = 32'h55555555; tick();
    push(32'h66666666, 1'b1);
    chk("prio_words", 32'(l_words), 32'd1);
    rd(16'd1200); chk("prio_w300", pa_dout, 32'h66666666);
    rd(16'd800);  chk("prio_w200", pa_dout, saved);

    // reset mid-load keeps words already written
    start(14'd100);
    push(32'hA0A00001, 1'b0);
    push(32'hA0A00002, 1'b0);
    quiet(); nreset = 0; tick();
    chk("abort_words", 32'(l_words), 32'h0);
    chk("abort_ready", 32'(l_ready), 32'h0);
    push(32'hFFFFFFFF, 1'b0);
    rd(16'd400); chk("abort_w0", pa_dout, 32'hA0A00001);
    rd(16'd404); chk("abort_w1", pa_dout, 32'hA0A00002);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      quiet();
      ls = ($urandom_range(49) == 0);
      lb = 14'($urandom);
      lv = ($urandom_range(9) < 7);
      ld = $urandom;
      ll = ($urandom_range(9) == 0);
      pa_addr = {14'($urandom_range(DEPTH - 1)), 2'b00};
      if ($urandom_range(9) == 0) pa_addr = 16'(m_ptr * 4);
      if ($urandom_range(29) == 0) pa_addr[1:0] = 2'($urandom_range(3, 1));
      pa_we = ($urandom_range(9) < 3);
      pa_din = $urandom;
      if ($urandom_range(199) == 0) begin
        nreset = 0; pa_we = 0; lv = 0;
      end
      tick();
    end

    quiet(); tick();
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sha1_msg_mem.md
SHA1_MSG_MEM -- requirements
Module: sha1_msg_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 16384, number of 32-bit words held (byte space 4*DEPTH_WORDS).
REQ-002 Parameter WADDR_W, default 14, word-address width, equal to log2(DEPTH_WORDS).
REQ-003 Reset nreset, synchronous, active-low; clock clk.
REQ-004 clk  in  1  sole clock; the hash core's port_A_clk is tied to clk.
REQ-005 nreset  in  1  synchronous active-low reset.
REQ-006 port_A_addr  in  16  byte address from the hash core.
REQ-007 port_A_we  in  1  1=write, 0=read.
REQ-008 port_A_data_in  in  32  write data from the hash core.
REQ-009 port_A_data_out  out  32  registered read data to the hash core.
REQ-010 load_start  in  1  pulse that begins a host load.
REQ-011 load_base  in  WADDR_W  first word address of the load.
REQ-012 load_valid  in  1  load_data/load_last valid.
REQ-013 load_data  in  32  message word, stored unmodified.
REQ-014 load_last  in  1  marks the final word of the load.
REQ-015 load_ready  out  1  block accepts a load word this cycle.
REQ-016 load_done  out  1  load complete.
REQ-017 load_words  out  WADDR_W+1  words accepted in the current or last load.
REQ-018 align_err  out  1  sticky misaligned-access flag.
REQ-019 err_addr  out  16  address of the first misaligned access.

Function
REQ-020 Port A aligned read (addr[1:0]==0, we=0): port_A_data_out SHALL equal mem[addr>>2] on the following rising clk edge, a one-cycle latency.
REQ-021 Port A aligned write (we=1): mem[addr>>2] SHALL be written at the clk edge, and port_A_data_out SHALL hold its prior value.
REQ-022 Port A misaligned access: no memory read or write SHALL occur, and port_A_data_out SHALL hold its value.
REQ-023 On a misaligned access, align_err SHALL set next cycle.
REQ-024 On the first misaligned access while align_err=0, err_addr SHALL capture port_A_addr; later misaligned accesses SHALL NOT update err_addr.
REQ-025 Port A SHALL be serviced every cycle, independent of the load FSM state.
REQ-026 Load FSM states SHALL be IDLE, LOAD and DONE.
REQ-027 load_start in any state SHALL enter LOAD, set the write pointer to load_base, clear load_words and clear load_done.
REQ-028 In LOAD, load_ready SHALL be 1; in IDLE and DONE, load_ready SHALL be 0.
REQ-029 In LOAD, load_start SHALL take priority over a same-cycle load_valid, which SHALL be dropped.
REQ-030 A load handshake is load_valid&load_ready; each handshake SHALL write mem[ptr]=load_data, increment ptr modulo DEPTH_WORDS, and increment load_words.
REQ-031 A handshake with load_last=1 SHALL move the FSM to DONE, with load_done=1 from the next cycle.
REQ-032 load_done SHALL hold until the next load_start.
REQ-033 load_words SHALL saturate at DEPTH_WORDS.
REQ-034 When the load port and port A write the same word in the same cycle, the load data SHALL win.
REQ-035 When the load port writes a word that port A reads in the same cycle, port A SHALL return the old data.

Reset
REQ-036 nreset=0 at a clk edge SHALL set the FSM to IDLE; load_ready, load_done, load_words, align_err, err_addr and port_A_data_out SHALL all become 0.
REQ-037 Reset SHALL NOT clear memory contents.
REQ-038 Reset during LOAD SHALL abort the load; words already written SHALL remain in memory.

Configuration
REQ-039 Feature macro SHA1_MEM_ACCESS_COUNT_EN controls two additional outputs, rd_count (32) and wr_count (32).
REQ-040 When SHA1_MEM_ACCESS_COUNT_EN is defined, rd_count and wr_count SHALL count aligned port A reads and writes respectively, reset to 0, and wrap at 2^32.
REQ-041 When SHA1_MEM_ACCESS_COUNT_EN is undefined, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-042 Load base=0, words 01234567, 02468ACE, 048D159C (last on the third word) -> load_words=3, load_done=1, and port A reads of addr 0, 4 and 8 return those words one cycle later.
REQ-043 Port A write 0xDEADBEEF at addr 0x0010, then read addr 0x0010 -> data_out=0xDEADBEEF one cycle after the read; data_out unchanged in the write cycle.
REQ-044 Port A read addr 0x0006, then read addr 0x0009 -> align_err=1, err_addr=0x0006, data_out unchanged, and no memory word modified.
REQ-045 Load base=16383, two words -> words stored at 16383 and 0 (wrap); load_words=2.
REQ-046 Same cycle: load writes 0x11111111 and port A writes 0x22222222, both to word 5 -> mem[5]=0x11111111.
REQ-047 nreset asserted after 2 of 4 load words -> FSM IDLE, load_words=0, and the first 2 words remain readable via port A.
